// File: rtl/multi_debouncer.sv
// multi_debouncer: CHANNELS independent debouncers for mechanical inputs.
// Each channel runs its raw input through a synchroniser chain. It then
// requires the synchronised level to differ from the current output for
// MAX_CLK_COUNT consecutive cycles before it accepts the new level.
// Each channel produces a clean level, one-cycle rise/fall pulses and an
// optional long-press pulse. any_change is a registered summary of all
// rise/fall pulses.
module multi_debouncer #(
    parameter int CHANNELS    = 4,
    parameter int CLK_FREQ    = 50,
    parameter int TIME_DELAY  = 1,
    parameter int HOLD_TIME   = 0,
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_VALUE = 1'b0
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic [CHANNELS-1:0] value_in,
    output logic [CHANNELS-1:0] value_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] hold_pulse,
    output logic                any_change
);

    localparam int MAX_CLK_COUNT  = TIME_DELAY * CLK_FREQ * 1000;
    localparam int HOLD_CLK_COUNT = HOLD_TIME * CLK_FREQ * 1000;
    localparam int CNT_W          = $clog2(MAX_CLK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CLK_COUNT - 1);

    // Parameter sanity: a window shorter than two cycles cannot filter anything.
    if (MAX_CLK_COUNT < 2) begin : g_bad_max
        $error("multi_debouncer: MAX_CLK_COUNT must be at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("multi_debouncer: SYNC_STAGES must be at least 2");
    end
    if (CHANNELS < 1) begin : g_bad_ch
        $error("multi_debouncer: CHANNELS must be at least 1");
    end

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic any_change_reg;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   sync_bit;
            state_t                 state_reg, state_next;
            logic [CNT_W-1:0]       cnt_reg, cnt_next;
            logic                   out_reg, out_next;
            logic                   rise_reg, rise_next;
            logic                   fall_reg, fall_next;

            // Shift the raw input through the synchroniser chain; only the last stage is used.
            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) begin
                    sync_reg <= {SYNC_STAGES{RESET_VALUE}};
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], value_in[gi]};
                end
            end

            assign sync_bit = sync_reg[SYNC_STAGES-1];

            // State register: FSM state, stability counter, clean level and edge pulses.
            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) begin
                    state_reg <= ST_STABLE;
                    cnt_reg   <= '0;
                    out_reg   <= RESET_VALUE;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    out_reg   <= out_next;
                    rise_reg  <= rise_next;
                    fall_reg  <= fall_next;
                end
            end

            // Next state: leave STABLE on a mismatch, return on agreement or a completed window.
            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    ST_STABLE: begin
                        if (sync_bit != out_reg) begin
                            state_next = ST_PENDING;
                        end
                    end
                    ST_PENDING: begin
                        if ((sync_bit == out_reg) || (cnt_reg == CNT_LAST)) begin
                            state_next = ST_STABLE;
                        end
                    end
                    default: state_next = ST_STABLE;
                endcase
            end

            // Outputs: count mismatching cycles and accept the new level once the window is full.
            always_comb begin
                cnt_next  = '0;
                out_next  = out_reg;
                rise_next = 1'b0;
                fall_next = 1'b0;
                case (state_reg)
                    ST_STABLE: begin
                        // The first mismatching edge already counts towards the window.
                        if (sync_bit != out_reg) begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    ST_PENDING: begin
                        // Agreement falls through with cnt_next = 0: a restart, never a decrement.
                        if (sync_bit != out_reg) begin
                            if (cnt_reg == CNT_LAST) begin
                                out_next  = sync_bit;
                                rise_next = sync_bit;
                                fall_next = ~sync_bit;
                            end else begin
                                cnt_next = cnt_reg + 1'b1;
                            end
                        end
                    end
                    default: cnt_next = '0;
                endcase
            end

            assign value_out[gi]  = out_reg;
            assign rise_pulse[gi] = rise_reg;
            assign fall_pulse[gi] = fall_reg;

            if (HOLD_CLK_COUNT > 0) begin : g_hold
                localparam int HCNT_W = $clog2(HOLD_CLK_COUNT + 1);
                localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CLK_COUNT - 1);
                localparam logic [HCNT_W-1:0] HOLD_FULL = HCNT_W'(HOLD_CLK_COUNT);

                logic [HCNT_W-1:0] hcnt_reg;
                logic              hold_reg;

                // Count cycles with the output high; saturate after the single long-press pulse.
                always_ff @(posedge clk or negedge rstN) begin
                    if (!rstN) begin
                        hcnt_reg <= '0;
                        hold_reg <= 1'b0;
                    end else begin
                        hold_reg <= 1'b0;
                        if (!out_reg) begin
                            hcnt_reg <= '0;
                        end else if (hcnt_reg == HOLD_LAST) begin
                            hcnt_reg <= HOLD_FULL;
                            hold_reg <= 1'b1;
                        end else if (hcnt_reg != HOLD_FULL) begin
                            hcnt_reg <= hcnt_reg + 1'b1;
                        end
                    end
                end

                assign hold_pulse[gi] = hold_reg;
            end else begin : g_no_hold
                assign hold_pulse[gi] = 1'b0;
            end
        end
    endgenerate

    // Flag, one cycle late, that at least one channel produced an edge pulse.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            any_change_reg <= 1'b0;
        end else begin
            any_change_reg <= |(rise_pulse | fall_pulse);
        end
    end

    assign any_change = any_change_reg;

endmodule

// File: tb/tb_multi_debouncer.sv
// Testbench for multi_debouncer: directed corner cases, a vector table and
// randomized bouncing inputs checked every cycle against a window-based
// reference model.
module tb_multi_debouncer;

    localparam int CH    = 4;
    localparam int SS    = 2;
    localparam int MAXC  = 1000;     // 1 ms at 1 MHz
    localparam int HOLDC = 3000;     // 3 ms at 1 MHz
    localparam int HN    = 65536;
    localparam int BIG   = 1000000;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic [CH-1:0] value_in = '0;
    logic [CH-1:0] value_out, rise_pulse, fall_pulse, hold_pulse;
    logic          any_change;
    logic [CH-1:0] pu_out, pu_rise, pu_fall, pu_hold;
    logic          pu_any;

    multi_debouncer #(
        .CHANNELS(CH), .CLK_FREQ(1), .TIME_DELAY(1), .HOLD_TIME(3),
        .SYNC_STAGES(SS), .RESET_VALUE(1'b0)
    ) u_dut (
        .clk(clk), .rstN(rstN), .value_in(value_in),
        .value_out(value_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .hold_pulse(hold_pulse), .any_change(any_change)
    );

    // Pull-up variant without hold logic.
    multi_debouncer #(
        .CHANNELS(CH), .CLK_FREQ(1), .TIME_DELAY(1), .HOLD_TIME(0),
        .SYNC_STAGES(SS), .RESET_VALUE(1'b1)
    ) u_dut_pu (
        .clk(clk), .rstN(rstN), .value_in(value_in),
        .value_out(pu_out), .rise_pulse(pu_rise), .fall_pulse(pu_fall),
        .hold_pulse(pu_hold), .any_change(pu_any)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: raw samples per edge plus the edge at which the current run began.
    bit            samp_h  [CH][HN];
    int            since_h [CH][HN];
    int            edge_n;
    int            rise_edge [CH];
    logic [CH-1:0] m_out, m_rise, m_fall, m_hold;
    logic          m_any;
    int            cnt_rise, cnt_fall, cnt_hold;

    typedef struct {
        logic [CH-1:0] vin;
        int            cycles;
        logic [CH-1:0] exp_out;
        int            exp_rise;
        int            exp_fall;
    } vec_t;

    vec_t vecs [6];

    function automatic bit samp_at(int c, int n);
        return (n <= 0) ? 1'b0 : samp_h[c][n];
    endfunction

    function automatic int since_at(int c, int n);
        return (n <= 0) ? -BIG : since_h[c][n];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (edge %0d): got 0x%0h, expected 0x%0h", name, edge_n, act, exp);
        end
    endtask

    task automatic model_reset();
        edge_n = 0;
        m_out  = '0;
        m_rise = '0;
        m_fall = '0;
        m_hold = '0;
        m_any  = 1'b0;
        for (int c = 0; c < CH; c++) rise_edge[c] = -BIG;
    endtask

    // Output changes at edge t when the samples seen through the synchroniser over the last
    // MAXC edges all agree and differ from the current output.
    task automatic model_edge();
        int k;
        bit s;
        edge_n++;
        m_any = |(m_rise | m_fall);
        for (int c = 0; c < CH; c++) begin
            samp_h[c][edge_n]  = value_in[c];
            since_h[c][edge_n] = (value_in[c] == samp_at(c, edge_n - 1)) ? since_at(c, edge_n - 1) : edge_n;
            m_hold[c] = m_out[c] && ((edge_n - rise_edge[c]) == HOLDC);
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
            k = edge_n - SS;
            s = samp_at(c, k);
            if ((s != m_out[c]) && (since_at(c, k) <= k - MAXC + 1)) begin
                m_out[c] = s;
                if (s) begin
                    m_rise[c]    = 1'b1;
                    rise_edge[c] = edge_n;
                end else begin
                    m_fall[c]    = 1'b1;
                    rise_edge[c] = -BIG;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cnt_rise += $countones(rise_pulse);
        cnt_fall += $countones(fall_pulse);
        cnt_hold += $countones(hold_pulse);
        check("cycle", 32'({value_out, rise_pulse, fall_pulse, hold_pulse, any_change}),
              32'({m_out, m_rise, m_fall, m_hold, m_any}));
    endtask

    // Called just after a falling edge; the following rising edge is edge 1.
    task automatic do_reset(logic [CH-1:0] vin);
        rstN     = 1'b0;
        value_in = vin;
        #2;
        check("rst_main", 32'({value_out, rise_pulse, fall_pulse, hold_pulse, any_change}), 32'(0));
        check("rst_pullup", 32'({pu_out, pu_rise, pu_fall, pu_hold, pu_any}), 32'({4'hF, 13'd0}));
        rstN = 1'b1;
        model_reset();
        cnt_rise = 0;
        cnt_fall = 0;
        cnt_hold = 0;
    endtask

    initial begin
        int pu_pulses;
        int run_left [CH];

        vecs[0] = '{4'b0001,  999, 4'b0000, 0, 0};
        vecs[1] = '{4'b0000, 1500, 4'b0000, 0, 0};
        vecs[2] = '{4'b0011, 1100, 4'b0011, 2, 0};
        vecs[3] = '{4'b0001,  500, 4'b0011, 0, 0};
        vecs[4] = '{4'b0001, 1100, 4'b0001, 0, 1};
        vecs[5] = '{4'b1000, 1200, 4'b1000, 1, 1};

        model_reset();
        @(negedge clk);

        // All channels held high through reset and beyond.
        do_reset(4'hF);
        pu_pulses = 0;
        for (int e = 1; e <= 1001; e++) begin
            tick();
            pu_pulses += $countones(pu_rise | pu_fall | pu_hold) + int'(pu_any);
        end
        check("t1_out_1001", 32'(value_out), 32'(4'h0));
        tick();
        check("t1_out_1002", 32'(value_out), 32'(4'hF));
        check("t1_rise_1002", 32'(rise_pulse), 32'(4'hF));
        tick();
        check("t1_rise_1003", 32'(rise_pulse), 32'(4'h0));
        check("t1_any_1003", 32'(any_change), 32'(1));
        check("t1_pullup_out", 32'(pu_out), 32'(4'hF));
        check("t1_pullup_pulses", 32'(pu_pulses), 32'(0));

        // Single channel rise latency.
        do_reset(4'b0001);
        repeat (1001) tick();
        check("t3_out_1001", 32'(value_out), 32'(4'b0000));
        tick();
        check("t3_out_1002", 32'(value_out), 32'(4'b0001));
        check("t3_rise_1002", 32'(rise_pulse), 32'(4'b0001));
        check("t3_any_1002", 32'(any_change), 32'(0));
        tick();
        check("t3_rise_1003", 32'(rise_pulse), 32'(4'b0000));
        check("t3_any_1003", 32'(any_change), 32'(1));

        // Bounces shorter than the window never pass.
        do_reset(4'b0000);
        for (int e = 1; e <= 6000; e++) begin
            if (e <= 999) value_in[0] = 1'b1;
            else value_in[0] = (((e - 1000) / 500) % 2) == 1;
            tick();
        end
        check("t2_out", 32'(value_out), 32'(4'b0000));
        check("t2_pulses", 32'(cnt_rise + cnt_fall), 32'(0));

        // Staggered channels and a bouncing channel.
        do_reset(4'b0000);
        for (int e = 1; e <= 1400; e++) begin
            value_in[1] = 1'b1;
            value_in[2] = (e >= 300);
            value_in[3] = ((e / 100) % 2) == 1;
            tick();
            if (e == 1001) check("t4_ch1_1001", 32'(value_out[1]), 32'(0));
            if (e == 1002) check("t4_rise_1002", 32'(rise_pulse), 32'(4'b0010));
            if (e == 1300) check("t4_ch2_1300", 32'(value_out[2]), 32'(0));
            if (e == 1301) check("t4_rise_1301", 32'(rise_pulse), 32'(4'b0100));
        end
        check("t4_out", 32'(value_out), 32'(4'b0110));

        // Long press: one hold pulse, then release.
        do_reset(4'b0010);
        for (int e = 1; e <= 6100; e++) begin
            if (e == 5001) value_in = 4'b0000;
            tick();
            if (e == 1002) check("t5_rise_1002", 32'(rise_pulse), 32'(4'b0010));
            if (e == 4001) check("t5_hold_4001", 32'(hold_pulse), 32'(0));
            if (e == 4002) check("t5_hold_4002", 32'(hold_pulse), 32'(4'b0010));
            if (e == 6001) check("t5_out_6001", 32'(value_out), 32'(4'b0010));
            if (e == 6002) check("t5_fall_6002", 32'(fall_pulse), 32'(4'b0010));
        end
        check("t5_hold_count", 32'(cnt_hold), 32'(1));

        // Asynchronous reset in the middle of a pending count.
        do_reset(4'b0010);
        repeat (1002) tick();
        check("t6_pre_out", 32'(value_out), 32'(4'b0010));
        value_in = 4'b0011;
        repeat (502) tick();
        #2;
        rstN = 1'b0;
        #1;
        check("t6_async_out", 32'({value_out, rise_pulse, fall_pulse, hold_pulse, any_change}), 32'(0));
        rstN = 1'b1;
        model_reset();
        repeat (1001) tick();
        check("t6_out_1001", 32'(value_out), 32'(4'b0000));
        tick();
        check("t6_out_1002", 32'(value_out), 32'(4'b0011));
        check("t6_rise_1002", 32'(rise_pulse), 32'(4'b0011));

        // Vector table applied from a clean reset.
        do_reset(4'b0000);
        for (int i = 0; i < 6; i++) begin
            value_in = vecs[i].vin;
            cnt_rise = 0;
            cnt_fall = 0;
            repeat (vecs[i].cycles) tick();
            check($sformatf("tbl%0d_out", i), 32'(value_out), 32'(vecs[i].exp_out));
            check($sformatf("tbl%0d_rise", i), 32'(cnt_rise), 32'(vecs[i].exp_rise));
            check($sformatf("tbl%0d_fall", i), 32'(cnt_fall), 32'(vecs[i].exp_fall));
        end

        // Random run lengths, some longer than the window, checked every cycle.
        do_reset(4'b0000);
        for (int c = 0; c < CH; c++) run_left[c] = 0;
        for (int i = 0; i < 20000; i++) begin
            for (int c = 0; c < CH; c++) begin
                if (run_left[c] == 0) begin
                    value_in[c] = 1'($urandom_range(0, 1));
                    run_left[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1000, 4000))
                                                              : int'($urandom_range(1, 1100));
                end
                run_left[c]--;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
